tlb_op_ctrl: RTL

- Sequencing controller for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB), issued one at a time from the execute stage.
- Drives the TLB's search port 2, write port, read port and invtlb port. Returns captured results to the CSR unit.
- Sits between the execute/CSR logic and the TLB. Owns the pseudo-random replacement index used by TLBFILL.

---
 rtl/tlb_op_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer (SRCH/RD/WR/FILL/INV): IDLE -> EXEC (TLB strobe) -> RESP (res_valid).
// Define TLBOP_INV_ILLEGAL_EXC_EN to flag reserved op codes and invtlb op > 6 on res_err.
package tlb_op_ctrl_pkg;
    localparam int TLB_IDX_W = 4;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic                 found;
        logic [TLB_IDX_W-1:0] index;
    } tlb_result_t;
endpackage

module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int          TLBNUM    = 16,
    parameter int          IDX_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [18:0]      op_vppn,
    input  logic [9:0]       op_asid,
    input  logic [IDX_W-1:0] op_index,
    input  tlb_entry_t       op_entry,
    input  logic [4:0]       op_inv_op,
    input  logic [31:0]      op_inv_va,
    output logic [18:0]      s2_vppn,
    output logic             s2_va_bit12,
    output logic [9:0]       s2_asid,
    input  tlb_result_t      s2_result,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output tlb_entry_t       tlb_w_entry,
    output logic [IDX_W-1:0] tlb_r_index,
    input  tlb_entry_t       tlb_r_entry,
    output logic             invtlb_valid,
    output logic [4:0]       invtlb_op,
    output logic [9:0]       invtlb_asid,
    output logic [31:0]      invtlb_va,
    output logic             res_valid,
    output logic [2:0]       res_code,
    output logic             res_found,
    output logic [IDX_W-1:0] res_index,
    output tlb_entry_t       res_entry,
    output logic             res_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    logic [1:0]       state;
    logic [15:0]      lfsr;
    logic [2:0]       l_code;
    logic [18:0]      l_vppn;
    logic [9:0]       l_asid;
    logic [IDX_W-1:0] l_index;
    tlb_entry_t       l_entry;
    logic [4:0]       l_inv_op;
    logic [31:0]      l_inv_va;

    logic             lfsr_fb;
    logic [IDX_W-1:0] fill_idx;
    logic             in_exec;
    logic             is_srch, is_rd, is_wr, is_fill, is_inv, inv_legal;
    logic             do_write, do_inv, err_now;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign fill_idx = IDX_W'(lfsr & 16'(TLBNUM - 1));

    assign is_srch   = (l_code == OP_SRCH);
    assign is_rd     = (l_code == OP_RD);
    assign is_wr     = (l_code == OP_WR);
    assign is_fill   = (l_code == OP_FILL);
    assign is_inv    = (l_code == OP_INV);
    assign inv_legal = (l_inv_op <= 5'd6);

    // Strobes are masked by reset so an op caught mid-flight never touches the TLB
    assign in_exec  = (state == EXEC) && !reset;
    assign do_write = in_exec && (is_wr || is_fill);
    assign do_inv   = in_exec && is_inv && inv_legal;

`ifdef TLBOP_INV_ILLEGAL_EXC_EN
    assign err_now = (l_code > OP_INV) || (is_inv && !inv_legal);
`else
    assign err_now = 1'b0;
`endif

    assign op_ready     = (state == IDLE);
    assign res_valid    = (state == RESP) && !reset;
    assign res_code     = l_code;

    assign s2_vppn      = (in_exec && is_srch) ? l_vppn : '0;
    assign s2_asid      = (in_exec && is_srch) ? l_asid : '0;
    assign s2_va_bit12  = 1'b0;
    assign tlb_r_index  = (in_exec && is_rd) ? l_index : '0;
    assign tlb_we       = do_write;
    assign tlb_w_index  = do_write ? l_index : '0;
    assign tlb_w_entry  = do_write ? l_entry : '0;
    assign invtlb_valid = do_inv;
    assign invtlb_op    = do_inv ? l_inv_op : '0;
    assign invtlb_asid  = do_inv ? l_asid : '0;
    assign invtlb_va    = do_inv ? l_inv_va : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            l_code    <= '0;
            l_vppn    <= '0;
            l_asid    <= '0;
            l_index   <= '0;
            l_entry   <= '0;
            l_inv_op  <= '0;
            l_inv_va  <= '0;
            res_found <= 1'b0;
            res_index <= '0;
            res_entry <= '0;
            res_err   <= 1'b0;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        l_code   <= op_code;
                        l_vppn   <= op_vppn;
                        l_asid   <= op_asid;
                        l_index  <= (op_code == OP_FILL) ? fill_idx : op_index;
                        l_entry  <= op_entry;
                        l_inv_op <= op_inv_op;
                        l_inv_va <= op_inv_va;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_found <= is_srch && s2_result.found;
                    if (is_srch && s2_result.found)
                        res_index <= IDX_W'(s2_result.index);
                    else if (is_fill)
                        res_index <= l_index;
                    else
                        res_index <= '0;
                    res_entry <= is_rd ? tlb_r_entry : '0;
                    res_err   <= err_now;
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
